trap_shaper_param: RTL and testbench
====================================

Name: trap_shaper_param

Overview:
- Parametrised trapezoidal pulse shaper for unsigned ADC samples, the successor to the fixed K=L=5 / M=16 shaping filter.
- K, L, M, ADC width and output width are generic.
- Adds sample-valid gating, a warm-up (settled) indicator, output saturation with a sticky overflow flag, and a synchronous clear.
- Sits between the ADC capture stage and the amplitude/peak logic.

Parameters:
- ADC_W, 12, input sample width (unsigned).
- K, 5, rise delay in samples; 1 <= K <= L.
- L, 5, second delay in samples; K+L <= 64.
- M, 16, pole-zero multiplier; the recursion uses (M+1).
- ACC_W, 40, internal signed accumulator width for p and s.
- OUT_W, 32, signed output width; OUT_W <= ACC_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart; zeroes all state.
- in_valid  in  1  qualifies in_data; one sample per asserted cycle.
- in_data  in  ADC_W  unsigned ADC sample.
- out_valid  out  1  one-cycle strobe per processed sample.
- out_data  out  OUT_W  signed, saturated shaper output s(n).
- settled  out  1  high once K+L samples have been accepted since reset/clear.
- ovf  out  1  sticky saturation flag.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-low. Reset values: out_valid=0, out_data=0, settled=0, ovf=0. Reset also zeroes the delay line, pointers, counters, p and s.
- Delay line: circular buffer of K+L entries, zero-filled. The write pointer wraps from K+L-1 to 0. It advances only on in_valid. v(n-K), v(n-L) and v(n-K-L) are read at pointer offsets.
- Stage 1 (on in_valid): d(n) = v(n) - v(n-K) - v(n-L) + v(n-K-L). Inputs are zero-extended, d is signed with ADC_W+3 bits. d is registered together with a valid bit.
- Stage 2 (on stage-1 valid):
  - p(n) = p(n-1) + d(n).
  - s(n) = s(n-1) + p(n-1) + (M+1)*d(n), using the old p.
  - Both are ACC_W signed and wrap internally; they are not saturated.
- Output: out_data = s(n) saturated to the OUT_W signed range. Saturation sets ovf, which stays set until reset or clear.
- Latency: out_valid asserts exactly 2 cycles after the cycle in_valid was high, one strobe per sample.
- Gaps: idle cycles (in_valid=0) freeze all state. The output sequence is independent of gap pattern.
- Warm-up: a sample counter saturates at K+L. settled=1 from the out_valid of sample index K+L-1 (0-based) onward. Outputs before settled are still produced, with missing history read as zero.
- clear:
  - Has priority over in_valid in the same cycle; that sample is discarded.
  - Zeroes the delay line (all K+L entries in one cycle), p, s, counters, settled and ovf.
  - Kills in-flight pipeline valids, so no out_valid is issued for pre-clear samples.
- Back-to-back: in_valid may be high every cycle and full throughput is sustained.

Optional Feature:
- Macro: TRAP_SHAPER_PEAK_EN.
- Defined:
  - Adds parameter PEAK_THR (default 1000, signed OUT_W) and ports peak_valid (out, 1) and peak_data (out, OUT_W). Both reset to 0.
  - While out_data > PEAK_THR on out_valid, the block tracks the running maximum.
  - On the first out_valid with out_data <= PEAK_THR after tracking began, peak_valid pulses for one cycle with the maximum, and the tracker is rearmed.
  - clear rearms the tracker without emitting a peak.
- Undefined: these ports, the parameter and the tracker logic do not exist.

Test Plan:
- Impulse (defaults): in_data=100 for one sample then 0 for 12 samples, in_valid every cycle.
  - out_data sequence: 1700, 1800, 1900, 2000, 2100, -1200, -1300, -1400, -1500, -1600, 0, 0, 0.
  - First out_valid appears 2 cycles after the first in_valid.
- Gapped input: same impulse with in_valid high every third cycle -> identical out_data sequence, one out_valid per sample.
- Settling (defaults): constant samples -> settled rises with the 10th out_valid (index 9) and stays high.
- Saturation: OUT_W=16, impulse of 4095 -> first output is 32767 (17*4095=69615 clipped), ovf=1 and stays high through later samples.
- Clear mid-pulse: assert clear after the 3rd sample of an impulse run -> no further out_valid for the old samples, ovf=0 and settled=0. A new impulse of 100 reproduces 1700, 1800, ...
- Peak (TRAP_SHAPER_PEAK_EN, PEAK_THR=1000): impulse 100 -> a single peak_valid with peak_data=2100, asserted on the cycle out_data=-1200 is presented.

Source files
------------

// File: rtl/trap_shaper_param_if.sv
// Sample-in / shaped-out bus for trap_shaper_param.
// With TRAP_SHAPER_PEAK_EN defined the bus also carries the peak report.
interface trap_shaper_param_if #(
  parameter int ADC_W = 12,
  parameter int OUT_W = 32
);
  logic                    clear;
  logic                    in_valid;
  logic [ADC_W-1:0]        in_data;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    settled;
  logic                    ovf;
`ifdef TRAP_SHAPER_PEAK_EN
  logic                    peak_valid;
  logic signed [OUT_W-1:0] peak_data;

  modport master (
    output clear, in_valid, in_data,
    input  out_valid, out_data, settled, ovf, peak_valid, peak_data
  );
  modport slave (
    input  clear, in_valid, in_data,
    output out_valid, out_data, settled, ovf, peak_valid, peak_data
  );
`else
  modport master (
    output clear, in_valid, in_data,
    input  out_valid, out_data, settled, ovf
  );
  modport slave (
    input  clear, in_valid, in_data,
    output out_valid, out_data, settled, ovf
  );
`endif
endinterface

// File: rtl/trap_shaper_param.sv
// Parametrised trapezoidal shaper (K, L, M) for unsigned ADC samples, 2-cycle latency.
// Optional peak tracker is built only when TRAP_SHAPER_PEAK_EN is defined.
module trap_shaper_param #(
  parameter int ADC_W = 12,
  parameter int K     = 5,
  parameter int L     = 5,
  parameter int M     = 16,
  parameter int ACC_W = 40,
  parameter int OUT_W = 32
`ifdef TRAP_SHAPER_PEAK_EN
  ,
  parameter logic signed [OUT_W-1:0] PEAK_THR = 1000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  trap_shaper_param_if.slave  bus
);

  localparam int N  = K + L;
  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;
  localparam int DW = ADC_W + 3;

  localparam logic [PW-1:0] LAST_PTR = PW'(N - 1);
  localparam logic [CW-1:0] N_C      = CW'(N);
  localparam logic [CW-1:0] NM1_C    = CW'(N - 1);

  localparam logic signed [ACC_W-1:0] MP1  = ACC_W'(M + 1);
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic [PW-1:0] ptr_back(input logic [PW-1:0] p, input int off);
    int t;
    t = int'(p) - off;
    if (t < 0) t = t + N;
    return PW'(t);
  endfunction

  function automatic logic signed [DW-1:0] zext(input logic [ADC_W-1:0] x);
    return $signed({3'b000, x});
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DW-1:0] x);
    return $signed({{(ACC_W-DW){x[DW-1]}}, x});
  endfunction

  function automatic logic is_sat(input logic signed [ACC_W-1:0] x);
    return (x > OMAX) || (x < OMIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] y;
    if (x > OMAX)      y = OMAX;
    else if (x < OMIN) y = OMIN;
    else               y = x;
    return $signed(y[OUT_W-1:0]);
  endfunction

  logic [ADC_W-1:0]        dly [N];
  logic [PW-1:0]           wr_ptr;
  logic [CW-1:0]           cnt;
  logic signed [DW-1:0]    d_c;

  logic                    vld_p1;
  logic signed [DW-1:0]    d_p1;
  logic                    set_p1;

  logic signed [ACC_W-1:0] p_acc_p2;
  logic signed [ACC_W-1:0] s_acc_p2;
  logic signed [ACC_W-1:0] d_ext;
  logic signed [ACC_W-1:0] p_nxt;
  logic signed [ACC_W-1:0] s_nxt;
  logic signed [OUT_W-1:0] o_c;
  logic                    vld_p2;
  logic signed [OUT_W-1:0] out_data_p2;
  logic                    settled_p2;
  logic                    ovf_p2;

  // Stage 1: comb-difference v(n) - v(n-K) - v(n-L) + v(n-K-L); slot at wr_ptr still holds v(n-K-L)
  always_comb begin
    d_c = zext(bus.in_data)
        - zext(dly[ptr_back(wr_ptr, K)])
        - zext(dly[ptr_back(wr_ptr, L)])
        + zext(dly[wr_ptr]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
      d_p1   <= '0;
      set_p1 <= 1'b0;
      for (int i = 0; i < N; i++) dly[i] <= '0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
      d_p1   <= '0;
      set_p1 <= 1'b0;
      for (int i = 0; i < N; i++) dly[i] <= '0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        dly[wr_ptr] <= bus.in_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (cnt < N_C) cnt <= cnt + 1'b1;
        d_p1        <= d_c;
        set_p1      <= (cnt >= NM1_C);
      end
    end
  end

  // Stage 2: pole-zero recursion; s uses the p from before this update
  always_comb begin
    d_ext = sext(d_p1);
    p_nxt = p_acc_p2 + d_ext;
    s_nxt = s_acc_p2 + p_acc_p2 + MP1 * d_ext;
    o_c   = sat_out(s_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_acc_p2    <= '0;
      s_acc_p2    <= '0;
      vld_p2      <= 1'b0;
      out_data_p2 <= '0;
      settled_p2  <= 1'b0;
      ovf_p2      <= 1'b0;
    end else if (bus.clear) begin
      p_acc_p2    <= '0;
      s_acc_p2    <= '0;
      vld_p2      <= 1'b0;
      out_data_p2 <= '0;
      settled_p2  <= 1'b0;
      ovf_p2      <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        p_acc_p2    <= p_nxt;
        s_acc_p2    <= s_nxt;
        out_data_p2 <= o_c;
        if (is_sat(s_nxt)) ovf_p2     <= 1'b1;
        if (set_p1)        settled_p2 <= 1'b1;
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_data  = out_data_p2;
  assign bus.settled   = settled_p2;
  assign bus.ovf       = ovf_p2;

`ifdef TRAP_SHAPER_PEAK_EN
  logic                    trk;
  logic signed [OUT_W-1:0] pk_max;
  logic                    pk_vld_p2;
  logic signed [OUT_W-1:0] pk_data_p2;

  // Peak report lines up with the first sample that falls back to/below the threshold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trk        <= 1'b0;
      pk_max     <= '0;
      pk_vld_p2  <= 1'b0;
      pk_data_p2 <= '0;
    end else if (bus.clear) begin
      trk        <= 1'b0;
      pk_max     <= '0;
      pk_vld_p2  <= 1'b0;
    end else begin
      pk_vld_p2 <= 1'b0;
      if (vld_p1) begin
        if (o_c > PEAK_THR) begin
          trk <= 1'b1;
          if (!trk || (o_c > pk_max)) pk_max <= o_c;
        end else if (trk) begin
          pk_vld_p2  <= 1'b1;
          pk_data_p2 <= pk_max;
          trk        <= 1'b0;
        end
      end
    end
  end

  assign bus.peak_valid = pk_vld_p2;
  assign bus.peak_data  = pk_data_p2;
`endif

endmodule

// File: tb/tb_trap_shaper_param.sv
// Directed bench for trap_shaper_param: default instance plus a 16-bit-output instance for saturation.
module tb_trap_shaper_param;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  trap_shaper_param_if #(.ADC_W(12), .OUT_W(32)) a_if ();
  trap_shaper_param_if #(.ADC_W(12), .OUT_W(16)) b_if ();

  trap_shaper_param #(.ADC_W(12), .K(5), .L(5), .M(16), .ACC_W(40), .OUT_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );
  trap_shaper_param #(.ADC_W(12), .K(5), .L(5), .M(16), .ACC_W(40), .OUT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if)
  );

  logic signed [63:0] qa [$];
  logic               qs [$];
  logic signed [63:0] qb [$];
  logic               qbo [$];
  logic signed [63:0] pkq [$];
  logic signed [63:0] pko [$];

  always @(negedge clk) begin
    if (a_if.out_valid) begin
      qa.push_back({{32{a_if.out_data[31]}}, a_if.out_data});
      qs.push_back(a_if.settled);
    end
    if (b_if.out_valid) begin
      qb.push_back({{48{b_if.out_data[15]}}, b_if.out_data});
      qbo.push_back(b_if.ovf);
    end
  end

`ifdef TRAP_SHAPER_PEAK_EN
  always @(negedge clk) begin
    if (a_if.peak_valid) begin
      pkq.push_back({{32{a_if.peak_data[31]}}, a_if.peak_data});
      pko.push_back({{32{a_if.out_data[31]}}, a_if.out_data});
    end
  end
`endif

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int imp [13] = '{1700, 1800, 1900, 2000, 2100, -1200, -1300, -1400, -1500, -1600, 0, 0, 0};
  int satv [11] = '{32767, 32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768, -32768, 0};

  initial begin
    reset = 1'b0;
    a_if.clear = 1'b0; a_if.in_valid = 1'b0; a_if.in_data = '0;
    b_if.clear = 1'b0; b_if.in_valid = 1'b0; b_if.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_out_data",  a_if.out_data,  0);
    chk("rst_settled",   a_if.settled,   0);
    chk("rst_ovf",       a_if.ovf,       0);
    reset = 1'b1;
    tick();

    // impulse, back-to-back samples
    a_if.in_valid = 1'b1; a_if.in_data = 12'd100;
    tick();
    chk("lat_cycle1_valid", a_if.out_valid, 0);
    a_if.in_data = 12'd0;
    tick();
    chk("lat_cycle2_valid", a_if.out_valid, 1);
    chk("lat_cycle2_data",  a_if.out_data,  1700);
    repeat (11) tick();
    a_if.in_valid = 1'b0;
    repeat (4) tick();
    chk("imp_count", qa.size(), 13);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("imp_data[%0d]", i), (i < qa.size()) ? qa[i] : 64'bx, imp[i]);
      chk($sformatf("imp_settled[%0d]", i), (i < qs.size()) ? qs[i] : 1'bx, (i >= 9) ? 1 : 0);
    end
    chk("imp_ovf", a_if.ovf, 0);
`ifdef TRAP_SHAPER_PEAK_EN
    chk("peak_count", pkq.size(), 1);
    chk("peak_data", (pkq.size() > 0) ? pkq[0] : 64'bx, 2100);
    chk("peak_with_out", (pko.size() > 0) ? pko[0] : 64'bx, -1200);
`endif

    // clear, then the same impulse with in_valid every third cycle
    a_if.clear = 1'b1;
    tick();
    a_if.clear = 1'b0;
    chk("clr_settled", a_if.settled, 0);
    qa.delete(); qs.delete();
    for (int i = 0; i < 13; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_data  = (i == 0) ? 12'd100 : 12'd0;
      tick();
      a_if.in_valid = 1'b0;
      tick();
      tick();
    end
    repeat (3) tick();
    chk("gap_count", qa.size(), 13);
    for (int i = 0; i < 13; i++)
      chk($sformatf("gap_data[%0d]", i), (i < qa.size()) ? qa[i] : 64'bx, imp[i]);
    chk("gap_settled", a_if.settled, 1);

    // clear after the third sample of an impulse; the clear-cycle sample is discarded
    a_if.clear = 1'b1;
    tick();
    a_if.clear = 1'b0;
    qa.delete(); qs.delete();
    a_if.in_valid = 1'b1; a_if.in_data = 12'd100;
    tick();
    a_if.in_data = 12'd0;
    tick();
    tick();
    a_if.clear = 1'b1; a_if.in_data = 12'd4095;
    tick();
    a_if.clear = 1'b0; a_if.in_valid = 1'b0; a_if.in_data = 12'd0;
    repeat (4) tick();
    chk("midclr_count", qa.size(), 2);
    chk("midclr_valid", a_if.out_valid, 0);
    chk("midclr_settled", a_if.settled, 0);
    chk("midclr_ovf", a_if.ovf, 0);
    qa.delete(); qs.delete();
    a_if.in_valid = 1'b1; a_if.in_data = 12'd100;
    tick();
    a_if.in_data = 12'd0;
    repeat (5) tick();
    a_if.in_valid = 1'b0;
    repeat (3) tick();
    chk("reimp_count", qa.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("reimp_data[%0d]", i), (i < qa.size()) ? qa[i] : 64'bx, imp[i]);

    // saturation on the 16-bit-output instance
    chk("sat_ovf_before", b_if.ovf, 0);
    b_if.in_valid = 1'b1; b_if.in_data = 12'd4095;
    tick();
    b_if.in_data = 12'd0;
    repeat (10) tick();
    b_if.in_valid = 1'b0;
    repeat (4) tick();
    chk("sat_count", qb.size(), 11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("sat_data[%0d]", i), (i < qb.size()) ? qb[i] : 64'bx, satv[i]);
    chk("sat_ovf_first", (qbo.size() > 0) ? qbo[0] : 1'bx, 1);
    chk("sat_ovf_sticky", b_if.ovf, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
